sipo_deserializer: RTL and testbench

Serial-in/parallel-out receiver for N-bit frames, the receiving end of the team's shift-register serial links. It accepts one data bit per strobe, LSB-first or MSB-first as selected per frame, and assembles the word in a shift register. Completed words go to a one-entry output buffer with a valid/ready handshake. It flags overrun and frame-restart errors, and optionally checks parity.

---
 rtl/sipo_deserializer_pkg.sv | 18 +
 rtl/sipo_deserializer_out_buf.sv | 57 +++++
 rtl/sipo_deserializer.sv | 152 +++++++++++++++
 tb/tb_sipo_deserializer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the sipo_deserializer serial receiver.
package sipo_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Bit count 0..n must be representable without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_deserializer_out_buf.sv
// One-entry valid/ready holding register for assembled words and their parity status.
module sipo_out_buf
    import sipo_deserializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         load_perr,
    input  logic         p_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    output logic         parity_err,
    output logic         accept
);

    logic [N-1:0] p_data_r;
    logic         p_valid_r;
    logic         parity_err_r;
    logic         accept_s;

    // A completion is accepted when the slot is empty or is being drained this cycle.
    always_comb begin
        accept_s = 1'b0;
        if (load && (!p_valid_r || p_ready)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Holding register: load wins over drain, otherwise a transfer empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_data_r     <= {N{1'b0}};
            p_valid_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else if (accept_s) begin
            p_data_r     <= load_data;
            p_valid_r    <= 1'b1;
            parity_err_r <= load_perr;
        end else if (p_valid_r && p_ready) begin
            p_valid_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            p_valid_r    <= p_valid_r;
        end
    end

    assign p_data     = p_data_r;
    assign p_valid    = p_valid_r;
    assign parity_err = parity_err_r;
    assign accept     = accept_s;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with per-frame bit order and one-entry output buffer.
// Optional even-parity check enabled by defining PARITY_EN.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         frame_start,
    input  logic         dir,
    input  logic         p_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t        state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic [N-1:0]  sh_r, sh_nxt;
    logic          dir_r, dir_nxt;
    logic          busy_r;
    logic          overrun_r;
    logic          frame_err_r, frame_err_nxt;
    logic          load_s;
    logic [N-1:0]  load_data_s;
    logic          load_perr_s;
    logic          accept_s;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] s, input logic b, input logic d);
        logic [N-1:0] r;
        case (d)
            DIR_LSB_FIRST: r = {b, s[N-1:1]};
            DIR_MSB_FIRST: r = {s[N-2:0], b};
            default:       r = {b, s[N-1:1]};
        endcase
        return r;
    endfunction

    // Even parity over data plus parity bit; a set result means a mismatch.
    function automatic logic parity_fail(input logic [N-1:0] d, input logic pb);
        return ^{d, pb};
    endfunction

    // Next-state logic; a qualified frame_start always begins a fresh frame.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        sh_nxt        = sh_r;
        dir_nxt       = dir_r;
        frame_err_nxt = 1'b0;
        load_s        = 1'b0;
        load_data_s   = sh_r;
        load_perr_s   = 1'b0;
        if (sin_valid && frame_start) begin
            frame_err_nxt = (state_r != ST_IDLE);
            state_nxt     = ST_SHIFT;
            cnt_nxt       = CW'(1'b1);
            dir_nxt       = dir;
            sh_nxt        = shift_in({N{1'b0}}, sin, dir);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (sin_valid) begin
                        sh_nxt = shift_in(sh_r, sin, dir_r);
                        if (cnt_r == LAST_CNT) begin
                            cnt_nxt = {CW{1'b0}};
`ifdef PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt   = ST_IDLE;
                            load_s      = 1'b1;
                            load_data_s = sh_nxt;
`endif
                        end else begin
                            cnt_nxt = cnt_r + CW'(1'b1);
                        end
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (sin_valid) begin
                        state_nxt   = ST_IDLE;
                        cnt_nxt     = {CW{1'b0}};
                        load_s      = 1'b1;
                        load_data_s = sh_r;
                        load_perr_s = parity_fail(sh_r, sin);
                    end else begin
                        state_nxt = ST_PARITY;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Frame state, shift register and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            sh_r        <= {N{1'b0}};
            dir_r       <= DIR_LSB_FIRST;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            sh_r        <= sh_nxt;
            dir_r       <= dir_nxt;
            busy_r      <= (state_nxt != ST_IDLE);
            overrun_r   <= load_s && !accept_s;
            frame_err_r <= frame_err_nxt;
        end
    end

    sipo_out_buf #(.N(N)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_data  (load_data_s),
        .load_perr  (load_perr_s),
        .p_ready    (p_ready),
        .p_data     (p_data),
        .p_valid    (p_valid),
        .parity_err (parity_err),
        .accept     (accept_s)
    );

    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer; parity scenarios run when PARITY_EN is defined.
module tb_sipo_deserializer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         frame_start;
    logic         dir;
    logic         p_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;
    logic         parity_err;

    int           total = 0;
    int           bad = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_w;

    always #5 clk = ~clk;

    sipo_deserializer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .frame_start (frame_start),
        .dir         (dir),
        .p_ready     (p_ready),
        .p_data      (p_data),
        .p_valid     (p_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    // Each handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && p_valid && p_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_extra: got p_data=%h, expected no word", p_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (p_data !== exp_w) begin
                    bad++;
                    $display("FAIL scoreboard_word: got %h, expected %h", p_data, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] send_order(input logic [N-1:0] w, input logic d);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = d ? w[N-1-i] : w[i];
        return r;
    endfunction

    task automatic drive_bit(input logic b, input logic fs, input logic d);
        sin = b; sin_valid = 1'b1; frame_start = fs; dir = d;
        @(negedge clk);
        sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [N-1:0] w, input logic d, input int gap);
        logic [N-1:0] seq;
        seq = send_order(w, d);
        for (int i = 0; i < N; i++) begin
            drive_bit(seq[i], i == 0, d);
            if (i < N - 1 && gap > 0) idle(gap);
        end
`ifdef PARITY_EN
        if (gap > 0) idle(gap);
        drive_bit(^w, 1'b0, d);
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0; dir = 1'b0; p_ready = 1'b0;
        idle(3);
        total++;
        if ({p_data, p_valid, busy, overrun, frame_err, parity_err} !== {(N + 5){1'b0}}) begin
            bad++;
            $display("FAIL reset_state: got %h/%b%b%b%b%b, expected all zero",
                     p_data, p_valid, busy, overrun, frame_err, parity_err);
        end
        rst = 1'b0;
        idle(1);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b0 || p_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore: got busy=%b p_valid=%b, expected 0 0", busy, p_valid);
        end
    endtask

    task automatic test_lsb_first;
        logic [N-1:0] seq;
        seq = 8'b1010_0101;
        p_ready = 1'b1;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < N; i++) begin
            drive_bit(seq[i], i == 0, 1'b0);
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL lsb_busy: got busy=%b, expected 1", busy);
                end
            end
        end
`ifdef PARITY_EN
        drive_bit(1'b0, 1'b0, 1'b0);
`endif
        total++;
        if (p_valid !== 1'b1 || p_data !== 8'hA5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL lsb_word: got v=%b d=%h busy=%b, expected 1 a5 0", p_valid, p_data, busy);
        end
        idle(1);
        total++;
        if (p_valid !== 1'b0) begin
            bad++;
            $display("FAIL lsb_drain: got p_valid=%b, expected 0", p_valid);
        end
    endtask

    task automatic test_msb_first;
        logic [N-1:0] seq;
        seq = 8'b0011_1100;
        p_ready = 1'b1;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < N; i++) drive_bit(seq[i], i == 0, 1'b1);
`ifdef PARITY_EN
        drive_bit(1'b0, 1'b0, 1'b1);
`endif
        total++;
        if (p_valid !== 1'b1 || p_data !== 8'h3C) begin
            bad++;
            $display("FAIL msb_word: got v=%b d=%h, expected 1 3c", p_valid, p_data);
        end
        exp_q.push_back(8'hB1);
        send_frame(8'hB1, 1'b1, 0);
        total++;
        if (p_data !== 8'hB1) begin
            bad++;
            $display("FAIL msb_asym: got %h, expected b1", p_data);
        end
        idle(1);
    endtask

    task automatic test_overrun;
        p_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h22, 1'b0, 0);
        total++;
        if (overrun !== 1'b1 || p_data !== 8'h11 || p_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun_pulse: got ovr=%b d=%h v=%b, expected 1 11 1", overrun, p_data, p_valid);
        end
        idle(1);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_once: got overrun=%b, expected 0", overrun);
        end
        p_ready = 1'b1;
        idle(1);
        total++;
        if (p_valid !== 1'b0) begin
            bad++;
            $display("FAIL overrun_drain: got p_valid=%b, expected 0", p_valid);
        end
        p_ready = 1'b0;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b0, 0);
        exp_q.push_back(8'h44);
        begin
            logic [N-1:0] seq;
            seq = send_order(8'h44, 1'b1);
            for (int i = 0; i < N; i++) begin
`ifndef PARITY_EN
                if (i == N - 1) p_ready = 1'b1;
`endif
                drive_bit(seq[i], i == 0, 1'b1);
            end
`ifdef PARITY_EN
            p_ready = 1'b1;
            drive_bit(^(8'h44), 1'b0, 1'b1);
`endif
        end
        total++;
        if (overrun !== 1'b0 || p_valid !== 1'b1 || p_data !== 8'h44) begin
            bad++;
            $display("FAIL same_cycle_load: got ovr=%b v=%b d=%h, expected 0 1 44", overrun, p_valid, p_data);
        end
        idle(1);
    endtask

    task automatic test_gaps;
        p_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 2);
        total++;
        if (p_valid !== 1'b1 || p_data !== 8'h5A) begin
            bad++;
            $display("FAIL gap_word: got v=%b d=%h, expected 1 5a", p_valid, p_data);
        end
        idle(1);
    endtask

    task automatic test_restart;
        logic [3:0]   part;
        logic [N-1:0] seq;
        int           errs;
        part = 4'b1011;
        errs = 0;
        p_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_bit(part[i], i == 0, 1'b0);
        total++;
        if (frame_err !== 1'b0 || p_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_pre: got ferr=%b v=%b, expected 0 0", frame_err, p_valid);
        end
        exp_q.push_back(8'hC3);
        seq = send_order(8'hC3, 1'b1);
        for (int i = 0; i < N; i++) begin
            drive_bit(seq[i], i == 0, 1'b1);
            if (frame_err === 1'b1) errs++;
        end
`ifdef PARITY_EN
        drive_bit(^(8'hC3), 1'b0, 1'b1);
        if (frame_err === 1'b1) errs++;
`endif
        total++;
        if (errs != 1) begin
            bad++;
            $display("FAIL restart_ferr: got %0d pulses, expected 1", errs);
        end
        total++;
        if (p_valid !== 1'b1 || p_data !== 8'hC3) begin
            bad++;
            $display("FAIL restart_word: got v=%b d=%h, expected 1 c3", p_valid, p_data);
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        p_ready = 1'b0;
        send_frame(8'h77, 1'b0, 0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({p_data, p_valid, busy, overrun, frame_err, parity_err} !== {(N + 5){1'b0}}) begin
            bad++;
            $display("FAIL reset_async: got %h/%b%b%b%b%b, expected all zero",
                     p_data, p_valid, busy, overrun, frame_err, parity_err);
        end
        @(negedge clk);
        rst = 1'b0;
        p_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 0);
        total++;
        if (p_valid !== 1'b1 || p_data !== 8'h96) begin
            bad++;
            $display("FAIL reset_next: got v=%b d=%h, expected 1 96", p_valid, p_data);
        end
        idle(1);
    endtask

`ifdef PARITY_EN
    task automatic send_with_parity(input logic [N-1:0] w, input logic pb);
        logic [N-1:0] seq;
        seq = send_order(w, 1'b0);
        for (int i = 0; i < N; i++) drive_bit(seq[i], i == 0, 1'b0);
        drive_bit(pb, 1'b0, 1'b0);
    endtask

    task automatic test_parity;
        p_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_with_parity(8'hA5, 1'b0);
        total++;
        if (p_valid !== 1'b1 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_good: got v=%b perr=%b, expected 1 0", p_valid, parity_err);
        end
        p_ready = 1'b1;
        idle(1);
        p_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_with_parity(8'hA5, 1'b1);
        total++;
        if (p_valid !== 1'b1 || parity_err !== 1'b1) begin
            bad++;
            $display("FAIL parity_bad: got v=%b perr=%b, expected 1 1", p_valid, parity_err);
        end
        p_ready = 1'b1;
        idle(1);
        total++;
        if (p_valid !== 1'b0 || parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_clear: got v=%b perr=%b, expected 0 0", p_valid, parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_overrun();
        test_gaps();
        test_restart();
        test_reset_mid();
`ifdef PARITY_EN
        test_parity();
`endif
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d words pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
